// File: rtl/normalize_iter_pkg.sv
// Shared widths, bit positions and FSM encoding for the post-add/sub normalizer.
// Optional one-cycle left normalization is selected with NORM_FAST_SHIFT_EN.
package normalize_iter_pkg;

  localparam int EXP_W   = 8;
  localparam int MANT_W  = 28;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  localparam int CARRY_BIT  = 27;
  localparam int HIDDEN_BIT = 26;
  localparam int GRS_LSB    = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/normalize_iter_lzc28.sv
// 28-bit leading-zero counter (combinational); count = 28 for an all-zero input.
module lzc28 (
  input  logic [27:0] value,
  output logic [4:0]  count
);

  // Scanning upward lets the highest set bit win.
  always_comb begin
    count = 5'd28;
    for (int i = 0; i < 28; i++) begin
      if (value[i]) count = 5'(27 - i);
    end
  end

endmodule

// File: rtl/normalize_iter.sv
// Sequential normalizer feeding the rounding stage: hidden one lands at bit 26.
// NORM_FAST_SHIFT_EN selects single-cycle left normalization via lzc28.
module normalize_iter
  import normalize_iter_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              sign,
  input  logic [EXP_W-1:0]  exp,
  input  logic [MANT_W-1:0] mantis,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sign_out,
  output logic [EXP_W-1:0]  exp_out,
  output logic [MANT_W-1:0] mantis_out,
  output logic              zero,
  output logic              ovf,
  output logic              denorm,
  output logic [1:0]        state_dbg
);

  // Handshake: an operand transfers on a clock edge where in_valid && in_ready,
  // a result on an edge where out_valid && out_ready; valid must be held until then.
  state_t              state, state_n;
  logic [EXP_W-1:0]    e, e_n;
  logic [MANT_W-1:0]   m, m_n;
  logic                sign_r, sign_n;
  logic                zero_r, zero_n, ovf_r, ovf_n, denorm_r, denorm_n;

`ifdef NORM_FAST_SHIFT_EN
  logic [4:0]       lz;
  logic [4:0]       amt;
  logic [EXP_W-1:0] e_m1;

  lzc28 u_lzc (
    .value (m),
    .count (lz)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      e        <= '0;
      m        <= '0;
      sign_r   <= 1'b0;
      zero_r   <= 1'b0;
      ovf_r    <= 1'b0;
      denorm_r <= 1'b0;
    end else begin
      state    <= state_n;
      e        <= e_n;
      m        <= m_n;
      sign_r   <= sign_n;
      zero_r   <= zero_n;
      ovf_r    <= ovf_n;
      denorm_r <= denorm_n;
    end
  end

  always_comb begin
    state_n  = state;
    e_n      = e;
    m_n      = m;
    sign_n   = sign_r;
    zero_n   = zero_r;
    ovf_n    = ovf_r;
    denorm_n = denorm_r;
`ifdef NORM_FAST_SHIFT_EN
    amt  = lz - 5'd1;
    e_m1 = e - EXP_W'(1);
`endif
    case (state)
      IDLE: begin
        if (in_valid) begin
          sign_n   = sign;
          e_n      = (exp == '0) ? EXP_W'(1) : exp;
          m_n      = mantis;
          zero_n   = 1'b0;
          ovf_n    = 1'b0;
          denorm_n = 1'b0;
          state_n  = SHIFT;
        end
      end
      SHIFT: begin
        if (e == EXP_MAX) begin
          // inf/NaN encodings pass through untouched
          state_n = DONE;
        end else if (m == '0) begin
          e_n     = '0;
          zero_n  = 1'b1;
          state_n = DONE;
        end else if (m[CARRY_BIT]) begin
          m_n = {1'b0, m[MANT_W-1:GRS_LSB+2], m[GRS_LSB+1] | m[GRS_LSB]};
          e_n = e + EXP_W'(1);
          if (e_n == EXP_MAX) begin
            m_n   = '0;
            ovf_n = 1'b1;
          end
          state_n = DONE;
        end else if (m[HIDDEN_BIT]) begin
          state_n = DONE;
        end else begin
`ifdef NORM_FAST_SHIFT_EN
          // Clamp at e = 1; a clamped shift leaves the result denormal.
          if (EXP_W'(amt) > e_m1) begin
            m_n      = m << e_m1;
            e_n      = '0;
            denorm_n = 1'b1;
          end else begin
            m_n = m << amt;
            e_n = e - EXP_W'(amt);
          end
          state_n = DONE;
`else
          if (e == EXP_W'(1)) begin
            e_n      = '0;
            denorm_n = 1'b1;
            state_n  = DONE;
          end else begin
            m_n = m << 1;
            e_n = e - EXP_W'(1);
          end
`endif
        end
      end
      DONE: begin
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign sign_out   = sign_r;
  assign exp_out    = e;
  assign mantis_out = m;
  assign zero       = zero_r;
  assign ovf        = ovf_r;
  assign denorm     = denorm_r;
  assign state_dbg  = state;

endmodule

// File: tb/tb_normalize_iter.sv
// Self-checking bench for normalize_iter: directed vector table, backpressure,
// mid-operation reset, and randomized operands against a behavioural model.
module tb_normalize_iter;
  import normalize_iter_pkg::*;

  localparam int RW = 40;  // {sign, exp, mantissa, zero, ovf, denorm}

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic              sign;
  logic [EXP_W-1:0]  exp;
  logic [MANT_W-1:0] mantis;
  logic              out_valid;
  logic              out_ready;
  logic              sign_out;
  logic [EXP_W-1:0]  exp_out;
  logic [MANT_W-1:0] mantis_out;
  logic              zero;
  logic              ovf;
  logic              denorm;
  logic [1:0]        state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  logic [RW-1:0] exp_q[$];

  typedef struct {
    logic              s;
    logic [EXP_W-1:0]  ex;
    logic [MANT_W-1:0] mi;
    logic [EXP_W-1:0]  eo;
    logic [MANT_W-1:0] mo;
    logic              z;
    logic              o;
    logic              d;
    int                k;
  } vec_t;

  vec_t vecs[14];

  normalize_iter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sign       (sign),
    .exp        (exp),
    .mantis     (mantis),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sign_out   (sign_out),
    .exp_out    (exp_out),
    .mantis_out (mantis_out),
    .zero       (zero),
    .ovf        (ovf),
    .denorm     (denorm),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [RW-1:0] dut_result();
    return {sign_out, exp_out, mantis_out, zero, ovf, denorm};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic int exp_latency(input int k);
`ifdef NORM_FAST_SHIFT_EN
    return 1;
`else
    return k + 1;
`endif
  endfunction

  // Behavioural reference written straight from the shift rules.
  task automatic model(input logic s, input logic [EXP_W-1:0] ex, input logic [MANT_W-1:0] mi,
                       output logic [RW-1:0] res, output int k);
    logic [EXP_W-1:0]  e;
    logic [MANT_W-1:0] m;
    logic z, o, d;
    e = (ex == 0) ? 8'd1 : ex;
    m = mi; z = 0; o = 0; d = 0; k = 0;
    if (ex == 8'hFF) begin
    end else if (m == 0) begin
      e = 0; z = 1;
    end else if (m[27]) begin
      m = {1'b0, m[27:2], m[1] | m[0]};
      e = e + 8'd1;
      if (e == 8'hFF) begin m = 0; o = 1; end
    end else begin
      while (!m[26] && e != 8'd1) begin
        m = m << 1; e = e - 8'd1; k++;
      end
      if (!m[26]) begin e = 0; d = 1; end
    end
    res = {s, e, m, z, o, d};
  endtask

  // scoreboard: pop and compare on every result handshake
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", {24'd0, dut_result()}, 64'd0);
      end else begin
        logic [RW-1:0] e;
        e = exp_q.pop_front();
        check("result", {24'd0, dut_result()}, {24'd0, e});
      end
    end
  end

  // driver: send one operand, measure latency, optionally hold out_ready low
  task automatic run_op(input logic s, input logic [EXP_W-1:0] ex, input logic [MANT_W-1:0] mi,
                        input logic [RW-1:0] req, input int k, input int hold);
    int lat;
    @(negedge clk);
    sign = s; exp = ex; mantis = mi; in_valid = 1'b1;
    check("in_ready_idle", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    exp_q.push_back(req);
    #1 in_valid = 1'b0;
    check("in_ready_busy", {63'd0, in_ready}, 64'd0);
    lat = 0;
    while (!out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 64'(lat), 64'(exp_latency(k)));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; sign = ~s; exp = 8'h10; mantis = 28'h0000001;
      @(posedge clk); #1;
      check("hold_valid", {62'd0, out_valid, in_ready}, 64'd2);
      check("hold_data", {24'd0, dut_result()}, {24'd0, req});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [RW-1:0] req;
    int k;
    logic [EXP_W-1:0]  rex;
    logic [MANT_W-1:0] rmi;
    logic rs;

    vecs[0]  = '{1'b0, 8'h85, 28'h4000010, 8'h85, 28'h4000010, 0, 0, 0, 0};
    vecs[1]  = '{1'b1, 8'h85, 28'h0800000, 8'h82, 28'h4000000, 0, 0, 0, 3};
    vecs[2]  = '{1'b0, 8'h7F, 28'hC000003, 8'h80, 28'h6000001, 0, 0, 0, 0};
    vecs[3]  = '{1'b0, 8'h03, 28'h0100000, 8'h00, 28'h0400000, 0, 0, 1, 2};
    vecs[4]  = '{1'b1, 8'h42, 28'h0000000, 8'h00, 28'h0000000, 1, 0, 0, 0};
    vecs[5]  = '{1'b0, 8'hFE, 28'h8000000, 8'hFF, 28'h0000000, 0, 1, 0, 0};
    vecs[6]  = '{1'b1, 8'hFF, 28'h0123456, 8'hFF, 28'h0123456, 0, 0, 0, 0};
    vecs[7]  = '{1'b0, 8'h00, 28'h4000001, 8'h01, 28'h4000001, 0, 0, 0, 0};
    vecs[8]  = '{1'b0, 8'h00, 28'h0000010, 8'h00, 28'h0000010, 0, 0, 1, 0};
    vecs[9]  = '{1'b0, 8'h1B, 28'h0000001, 8'h01, 28'h4000000, 0, 0, 0, 26};
    vecs[10] = '{1'b1, 8'h1A, 28'h0000001, 8'h00, 28'h2000000, 0, 0, 1, 25};
    vecs[11] = '{1'b0, 8'h01, 28'h8000001, 8'h02, 28'h4000001, 0, 0, 0, 0};
    vecs[12] = '{1'b1, 8'h80, 28'h0000003, 8'h67, 28'h6000000, 0, 0, 0, 25};
    vecs[13] = '{1'b0, 8'hFF, 28'h0000000, 8'hFF, 28'h0000000, 0, 0, 0, 0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    sign = 1'b0; exp = '0; mantis = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_handshake", {62'd0, in_ready, out_valid}, 64'd2);
    check("reset_outputs", {24'd0, dut_result()}, 64'd0);
    check("reset_state", {62'd0, state_dbg}, {62'd0, IDLE});
    @(negedge clk) rst_n = 1'b1;

    // directed table
    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].s, vecs[i].ex, vecs[i].mi,
             {vecs[i].s, vecs[i].eo, vecs[i].mo, vecs[i].z, vecs[i].o, vecs[i].d},
             vecs[i].k, 0);
    end

    // backpressure: result held for 10 cycles while a new operand is offered
    run_op(1'b1, 8'h85, 28'h0800000, {1'b1, 8'h82, 28'h4000000, 3'b000}, 3, 10);
    run_op(1'b0, 8'h85, 28'h4000010, {1'b0, 8'h85, 28'h4000010, 3'b000}, 0, 0);

    // reset mid-operation discards the operand immediately
    @(negedge clk);
    sign = 1'b1; exp = 8'h1B; mantis = 28'h0000001; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midreset_handshake", {62'd0, in_ready, out_valid}, 64'd2);
    check("midreset_outputs", {24'd0, dut_result()}, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    run_op(1'b0, 8'h7F, 28'hC000003, {1'b0, 8'h80, 28'h6000001, 3'b000}, 0, 0);

    // randomized operands against the model
    for (int i = 0; i < 30; i++) begin
      rs  = 1'($urandom_range(0, 1));
      rex = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 30)) : 8'($urandom_range(0, 255));
      rmi = 28'($urandom()) >> $urandom_range(0, 27);
      model(rs, rex, rmi, req, k);
      run_op(rs, rex, rmi, req, k, 0);
    end

    repeat (3) @(posedge clk);
    #1 check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
